fc_requant_serializer: RTL and testbench

Downstream stage of the fully-connected core array. When the controller signals that a layer's accumulation has finished, this block captures all NUM_CORE 64-bit accumulator results in one cycle. It requantizes each one to 16-bit signed with a rounding arithmetic right shift, optional ReLU and saturation. It then streams the results out in core-index order over a valid/ready handshake toward the activation buffer.

---
 rtl/fc_requant_serializer.sv | 150 +++++++++++++++
 tb/tb_fc_requant_serializer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fc_requant_serializer.sv
// Captures NUM_CORE accumulators on i_done, requantizes each to IN_DATA_WITDH bits
// (rounding shift, optional ReLU, saturation) and streams them out in index order.
module fc_requant_serializer #(
  parameter int NUM_CORE      = 32,
  parameter int IN_DATA_WITDH = 16,
  parameter int SHIFT_W       = 6,
  parameter int IDX_W         = $clog2(NUM_CORE)
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                i_done,
  input  logic [NUM_CORE*4*IN_DATA_WITDH-1:0] i_result,
  input  logic [SHIFT_W-1:0]                  i_shift,
  input  logic                                i_relu_en,
  output logic                                o_busy,
  output logic                                o_valid,
  input  logic                                i_ready,
  output logic [IN_DATA_WITDH-1:0]            o_data,
  output logic [IDX_W-1:0]                    o_index,
  output logic                                o_last,
  output logic                                o_frame_done,
  output logic                                o_overrun
);

  localparam int ACC_W = 4 * IN_DATA_WITDH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CORE - 1);
  localparam logic signed [ACC_W:0] SAT_MAX =
    {{(ACC_W - IN_DATA_WITDH + 2){1'b0}}, {(IN_DATA_WITDH - 1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN =
    {{(ACC_W - IN_DATA_WITDH + 2){1'b1}}, {(IN_DATA_WITDH - 1){1'b0}}};

  typedef enum logic [1:0] {IDLE, PREP, SEND} state_t;

  state_t                    state_q, state_d;
  logic signed [ACC_W-1:0]   bank_q [NUM_CORE];
  logic signed [ACC_W-1:0]   bank_d [NUM_CORE];
  logic [SHIFT_W-1:0]        shift_q, shift_d;
  logic                      relu_q, relu_d;
  logic [IN_DATA_WITDH-1:0]  data_q, data_d;
  logic [IDX_W-1:0]          index_q, index_d, next_idx;
  logic                      valid_q, valid_d;
  logic                      last_q, last_d;
  logic                      frame_done_q, frame_done_d;
  logic                      overrun_q, overrun_d;

  // One extra bit of headroom keeps the round-half-up add from overflowing.
  function automatic logic [IN_DATA_WITDH-1:0] quant(
    input logic signed [ACC_W-1:0] a,
    input logic [SHIFT_W-1:0]      s,
    input logic                    relu
  );
    logic signed [ACC_W:0] v;
    logic signed [ACC_W:0] rnd;
    v   = {a[ACC_W-1], a};
    rnd = '0;
    if (s != '0) begin
      rnd = (ACC_W + 1)'(1) << (s - 1'b1);
      v   = (v + rnd) >>> s;
    end
    if (relu && v < 0) v = '0;
    if (v > SAT_MAX) v = SAT_MAX;
    else if (v < SAT_MIN) v = SAT_MIN;
    return v[IN_DATA_WITDH-1:0];
  endfunction

  assign next_idx = index_q + IDX_W'(1);

  always_comb begin
    state_d      = state_q;
    bank_d       = bank_q;
    shift_d      = shift_q;
    relu_d       = relu_q;
    data_d       = data_q;
    index_d      = index_q;
    valid_d      = valid_q;
    last_d       = last_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;
    case (state_q)
      IDLE: begin
        if (i_done) begin
          for (int k = 0; k < NUM_CORE; k++) bank_d[k] = i_result[k*ACC_W +: ACC_W];
          shift_d   = i_shift;
          relu_d    = i_relu_en;
          overrun_d = 1'b0;
          state_d   = PREP;
        end
      end
      PREP: begin
        data_d  = quant(bank_q[0], shift_q, relu_q);
        index_d = '0;
        valid_d = 1'b1;
        last_d  = 1'b0;
        state_d = SEND;
      end
      SEND: begin
        if (valid_q && i_ready) begin
          if (index_q == LAST_IDX) begin
            valid_d      = 1'b0;
            last_d       = 1'b0;
            frame_done_d = 1'b1;
            state_d      = IDLE;
          end else begin
            data_d  = quant(bank_q[next_idx], shift_q, relu_q);
            index_d = next_idx;
            last_d  = (next_idx == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A capture request while a frame is in flight is dropped but remembered.
    if (i_done && state_q != IDLE) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      for (int k = 0; k < NUM_CORE; k++) bank_q[k] <= '0;
      shift_q      <= '0;
      relu_q       <= 1'b0;
      data_q       <= '0;
      index_q      <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bank_q       <= bank_d;
      shift_q      <= shift_d;
      relu_q       <= relu_d;
      data_q       <= data_d;
      index_q      <= index_d;
      valid_q      <= valid_d;
      last_q       <= last_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign o_busy       = (state_q != IDLE);
  assign o_valid      = valid_q;
  assign o_data       = data_q;
  assign o_index      = index_q;
  assign o_last       = last_q;
  assign o_frame_done = frame_done_q;
  assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_fc_requant_serializer.sv
// Randomized bench for fc_requant_serializer against an arithmetic reference model.
module tb_fc_requant_serializer;

  localparam int NC = 32;
  localparam int W  = 16;
  localparam int AW = 64;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            i_done;
  logic [NC*AW-1:0] i_result;
  logic [5:0]      i_shift;
  logic            i_relu_en;
  logic            o_busy, o_valid, i_ready, o_last, o_frame_done, o_overrun;
  logic [W-1:0]    o_data;
  logic [4:0]      o_index;

  int checks = 0;
  int errors = 0;
  logic signed [AW-1:0] res [NC];

  fc_requant_serializer dut (
    .clk(clk), .reset_n(reset_n), .i_done(i_done), .i_result(i_result),
    .i_shift(i_shift), .i_relu_en(i_relu_en), .o_busy(o_busy), .o_valid(o_valid),
    .i_ready(i_ready), .o_data(o_data), .o_index(o_index), .o_last(o_last),
    .o_frame_done(o_frame_done), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Floor division of (a + 2^(s-1)) by 2^s, then ReLU and clamp.
  function automatic logic [W-1:0] model_quant(input logic signed [AW-1:0] a, input int s, input bit relu);
    logic signed [127:0] num, d, q;
    num = a;
    if (s == 0) q = num;
    else begin
      d   = 128'sd1 << s;
      num = num + d / 2;
      q   = num / d;
      if (num < 0 && q * d != num) q = q - 1;
    end
    if (relu && q < 0) q = 0;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return q[W-1:0];
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic run_frame(input int shift, input bit relu, input int ready_pct,
                           input bit inject, input int reset_at);
    int   exp_idx, guard;
    bit   rdy, prev_stall, injected10;
    logic [W-1:0] prev_data;
    logic [4:0]   prev_idx;
    for (int k = 0; k < NC; k++) i_result[k*AW +: AW] = res[k];
    i_shift   = 6'(shift);
    i_relu_en = relu;
    i_done    = 1'b1;
    i_ready   = 1'b0;
    @(negedge clk);
    i_done   = 1'b0;
    i_result = {NC{rand64()}};
    i_shift  = 6'($urandom);
    check_output("busy_n1", o_busy, 1);
    check_output("valid_n1", o_valid, 0);
    check_output("overrun_clr", o_overrun, 0);
    exp_idx = 0; guard = 0; prev_stall = 0; injected10 = 0;
    prev_data = '0; prev_idx = '0;
    while (exp_idx < NC && guard < 2000) begin
      @(negedge clk);
      guard++;
      i_done = 1'b0;
      check_output("valid", o_valid, 1);
      check_output("busy", o_busy, 1);
      check_output("index", o_index, exp_idx);
      check_output("data", o_data, model_quant(res[exp_idx], shift, relu));
      check_output("last", o_last, exp_idx == NC - 1);
      check_output("fdone_mid", o_frame_done, 0);
      if (prev_stall) begin
        check_output("hold_data", o_data, prev_data);
        check_output("hold_idx", o_index, prev_idx);
      end
      if (reset_at == exp_idx) begin
        reset_n = 1'b0;
        #1;
        check_output("rst_valid", o_valid, 0);
        check_output("rst_busy", o_busy, 0);
        check_output("rst_data", o_data, 0);
        check_output("rst_index", o_index, 0);
        check_output("rst_last", o_last, 0);
        check_output("rst_fdone", o_frame_done, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) begin
          @(negedge clk);
          check_output("rst_no_fdone", o_frame_done, 0);
          check_output("rst_idle", o_busy, 0);
        end
        return;
      end
      rdy = ($urandom_range(99) < ready_pct);
      if (inject && ((exp_idx == 10 && !injected10) || (exp_idx == NC - 1 && rdy))) begin
        i_done = 1'b1;
        i_result = {NC{rand64()}};
        if (exp_idx == 10) injected10 = 1;
      end
      i_ready    = rdy;
      prev_stall = !rdy;
      prev_data  = o_data;
      prev_idx   = o_index;
      if (rdy) exp_idx++;
    end
    check_output("timeout", guard < 2000, 1);
    @(negedge clk);
    i_done  = 1'b0;
    i_ready = 1'b0;
    check_output("fdone", o_frame_done, 1);
    check_output("busy_end", o_busy, 0);
    check_output("valid_end", o_valid, 0);
    check_output("overrun", o_overrun, inject);
    @(negedge clk);
    check_output("fdone_pulse", o_frame_done, 0);
  endtask

  task automatic applyStimulus();
    // Passthrough
    for (int k = 0; k < NC; k++) res[k] = 64'(k - 16);
    run_frame(0, 0, 100, 0, -1);
    // Rounding
    for (int k = 0; k < NC; k++) res[k] = 64'($signed($urandom_range(2000)) - 1000);
    res[0] = 8; res[1] = 7; res[2] = -8; res[3] = -9; res[4] = 24;
    run_frame(4, 0, 100, 0, -1);
    // Saturation with and without ReLU
    for (int k = 0; k < NC; k++) res[k] = rand64();
    res[0] = 40000; res[1] = -40000; res[2] = -5;
    run_frame(0, 1, 100, 0, -1);
    run_frame(0, 0, 100, 0, -1);
    // Backpressure
    for (int k = 0; k < NC; k++) res[k] = 64'($signed($urandom_range(400000)) - 200000);
    run_frame(2, 0, 30, 0, -1);
    // Overrun, then a clean frame that must clear it on capture
    run_frame($urandom_range(8), 1, 100, 1, -1);
    run_frame(3, 0, 70, 0, -1);
    // Reset mid-frame, then restart
    run_frame(1, 0, 100, 0, 5);
    for (int k = 0; k < NC; k++) res[k] = rand64();
    run_frame($urandom_range(63), $urandom_range(1), 70, 0, -1);
    // Random full-range frames
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < NC; k++) res[k] = rand64();
      run_frame($urandom_range(63), $urandom_range(1), $urandom_range(20, 100), 0, -1);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    i_done    = 1'b0;
    i_ready   = 1'b0;
    i_result  = '0;
    i_shift   = '0;
    i_relu_en = 1'b0;
    repeat (2) @(negedge clk);
    check_output("reset_busy", o_busy, 0);
    check_output("reset_valid", o_valid, 0);
    check_output("reset_data", o_data, 0);
    check_output("reset_index", o_index, 0);
    check_output("reset_overrun", o_overrun, 0);
    check_output("reset_fdone", o_frame_done, 0);
    reset_n = 1'b1;
    @(negedge clk);
    applyStimulus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
